// File: rtl/mips_soc_top.sv
// rtl/mips_soc_top.sv - single-cycle MIPS core with imem/dmem, memory-mapped IO and run/halt/step debug control
// The debug FSM gates the core clock-enable, which allows single-stepping and breakpoints on fetch PC.
module mips_soc_top #(
  parameter int IMEM_AW      = 6,
  parameter int DMEM_AW      = 6,
  parameter int GPIO_W       = 8,
  parameter int START_HALTED = 0,
  parameter logic [32*(2**IMEM_AW)-1:0] IMEM_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_halt_req,
  input  logic              dbg_step_req,
  input  logic              dbg_resume_req,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [4:0]        ra_debug,
  output logic [31:0]       ra_debug_data,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic [31:0]       writedata,
  output logic [31:0]       dataadr,
  output logic              memwrite,
  output logic              halted,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [31:0]       retired
);
  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;

  state_t            state_q;
  logic              skip_bp_q;
  logic [31:0]       pc_q, pc_d, cycle_q, retired_q;
  logic [GPIO_W-1:0] gpio_q;
  logic [31:0]       rf_q   [0:31];
  logic [31:0]       dmem_q [0:2**DMEM_AW-1];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wr_idx;
  logic [31:0] simm, rs_val, rt_val, srcb, alu_y, wb_data, pc_plus4;
  logic [31:0] readdata, io_rdata, dmem_rdata;
  logic        is_r, is_lw, is_sw, is_beq, is_addi, is_lui, is_j;
  logic        reg_we, io_sel, bp_hit, cpu_en;

  assign pc     = pc_q;
  assign instr  = IMEM_INIT[{pc_q[IMEM_AW+1:2], 5'd0} +: 32];
  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign funct  = instr[5:0];
  assign simm   = {{16{instr[15]}}, instr[15:0]};

  assign is_r    = (op == 6'h00);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2b);
  assign is_beq  = (op == 6'h04);
  assign is_addi = (op == 6'h08);
  assign is_lui  = (op == 6'h0f);
  assign is_j    = (op == 6'h02);
  assign reg_we  = is_r | is_lw | is_addi | is_lui;
  assign wr_idx  = is_r ? rd : rt;

  assign rs_val        = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rt_val        = (rt == 5'd0) ? 32'd0 : rf_q[rt];
  assign ra_debug_data = (ra_debug == 5'd0) ? 32'd0 : rf_q[ra_debug];
  assign srcb          = (is_r | is_beq) ? rt_val : simm;

  always_comb begin
    alu_y = rs_val + srcb;
    if (is_r) begin
      case (funct)
        6'h20:   alu_y = rs_val + srcb;
        6'h22:   alu_y = rs_val - srcb;
        6'h24:   alu_y = rs_val & srcb;
        6'h25:   alu_y = rs_val | srcb;
        6'h2a:   alu_y = {31'd0, $signed(rs_val) < $signed(srcb)};
        default: alu_y = 32'd0;
      endcase
    end
  end

  assign pc_plus4 = pc_q + 32'd4;
  always_comb begin
    pc_d = pc_plus4;
    if (is_beq && (rs_val == rt_val)) pc_d = pc_plus4 + {simm[29:0], 2'b00};
    else if (is_j)                    pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
  end

  assign dataadr   = alu_y;
  assign writedata = rt_val;
  assign io_sel    = (dataadr[31:28] == 4'hF);

  // skip_bp lets a resume step off the breakpoint PC it halted on
  assign bp_hit   = bp_en & (pc_q == bp_addr) & ~skip_bp_q;
  assign cpu_en   = (state_q == S_STEP) | ((state_q == S_RUN) & ~bp_hit & ~dbg_halt_req);
  assign memwrite = is_sw & cpu_en;
  assign halted   = (state_q == S_HALT);
  assign gpio_out = gpio_q;
  assign retired  = retired_q;

  always_comb begin
    io_rdata = 32'd0;
    case (dataadr[27:0])
      28'h0:   io_rdata = 32'(gpio_q);
      28'h4:   io_rdata = cycle_q;
      28'h8:   io_rdata = retired_q;
      default: io_rdata = 32'd0;
    endcase
  end

  assign dmem_rdata = dmem_q[dataadr[DMEM_AW+1:2]];
  assign readdata   = io_sel ? io_rdata : dmem_rdata;
  assign wb_data    = is_lw ? readdata : (is_lui ? {instr[15:0], 16'h0000} : alu_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= (START_HALTED != 0) ? S_HALT : S_RUN;
      skip_bp_q <= 1'b0;
      gpio_q    <= '0;
      cycle_q   <= 32'd0;
      retired_q <= 32'd0;
      pc_q      <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (cpu_en) begin
        retired_q <= retired_q + 32'd1;
        pc_q      <= pc_d;
      end
      if (memwrite && io_sel && (dataadr[27:0] == 28'h0)) gpio_q <= writedata[GPIO_W-1:0];
      case (state_q)
        S_RUN: begin
          if (dbg_halt_req || bp_hit) state_q   <= S_HALT;
          else                        skip_bp_q <= 1'b0;
        end
        S_HALT: begin
          if (dbg_step_req) state_q <= S_STEP;
          else if (dbg_resume_req) begin
            state_q   <= S_RUN;
            skip_bp_q <= 1'b1;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_en && !rst && reg_we && (wr_idx != 5'd0)) rf_q[wr_idx] <= wb_data;
  end

  always_ff @(negedge clk) begin
    if (memwrite && !rst && !io_sel) dmem_q[dataadr[DMEM_AW+1:2]] <= writedata;
  end
endmodule

// File: tb/tb_mips_soc_top.sv
// tb/tb_mips_soc_top.sv - directed bench for mips_soc_top debug control, IO map and core datapath
module tb_mips_soc_top;
  localparam logic [2047:0] PROG = {
    {48{32'h0000_0000}},
    32'h1000FFFF,  // 3C beq $0,$0,-1
    32'h00236024,  // 38 and $12,$1,$3
    32'h00235825,  // 34 or  $11,$1,$3
    32'h8C0A0024,  // 30 lw  $10,0x24($0)
    32'hAC040024,  // 2C sw  $4,0x24($0)
    32'h8C49000C,  // 28 lw  $9,12($2)
    32'h00C3382A,  // 24 slt $7,$6,$3
    32'h00813022,  // 20 sub $6,$4,$1
    32'h00A32020,  // 1C add $4,$5,$3
    32'h8C050020,  // 18 lw  $5,0x20($0)
    32'h8C480008,  // 14 lw  $8,8($2)
    32'hAC410000,  // 10 sw  $1,0($2)
    32'hAC030020,  // 0C sw  $3,0x20($0)
    32'h20030005,  // 08 addi $3,$0,5
    32'h3C02F000,  // 04 lui $2,0xF000
    32'h200100A5   // 00 addi $1,$0,0xA5
  };

  logic        clk = 1'b0, rst = 1'b1;
  logic        dbg_halt_req = 0, dbg_step_req = 0, dbg_resume_req = 0, bp_en = 0;
  logic [31:0] bp_addr = 32'd0;
  logic [4:0]  ra_debug = 5'd0;
  logic [31:0] ra_debug_data, pc, instr, writedata, dataadr, retired;
  logic        memwrite, halted;
  logic [7:0]  gpio_out;
  int          n_total = 0, n_bad = 0;

  mips_soc_top #(.IMEM_AW(6), .DMEM_AW(6), .GPIO_W(8), .START_HALTED(1), .IMEM_INIT(PROG)) dut (
    .clk(clk), .rst(rst), .dbg_halt_req(dbg_halt_req), .dbg_step_req(dbg_step_req),
    .dbg_resume_req(dbg_resume_req), .bp_en(bp_en), .bp_addr(bp_addr), .ra_debug(ra_debug),
    .ra_debug_data(ra_debug_data), .pc(pc), .instr(instr), .writedata(writedata),
    .dataadr(dataadr), .memwrite(memwrite), .halted(halted), .gpio_out(gpio_out), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_halt", {31'd0, halted}, 32'd1);
  endtask

  task automatic do_step(input logic with_resume, input logic [31:0] exp_pc, input logic [31:0] exp_ret);
    dbg_step_req = 1'b1;
    dbg_resume_req = with_resume;
    tick(1);
    dbg_step_req = 1'b0;
    dbg_resume_req = 1'b0;
    tick(1);
    check("step_halted", {31'd0, halted}, 32'd1);
    check("step_pc", pc, exp_pc);
    check("step_retired", retired, exp_ret);
  endtask

  task automatic step_reset(input logic exp_mw);
    dbg_step_req = 1'b1;
    @(posedge clk);
    #1;
    check("in_step_mw", {31'd0, memwrite}, {31'd0, exp_mw});
    check("in_step_halted", {31'd0, halted}, 32'd0);
    rst = 1'b1;
    dbg_step_req = 1'b0;
    #1;
    check("rst_mw", {31'd0, memwrite}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd1);
    check("rst_pc", pc, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_gpio", {24'd0, gpio_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);
  endtask

  logic [4:0]  reg_idx [10] = '{5'd8, 5'd5, 5'd4, 5'd6, 5'd7, 5'd9, 5'd10, 5'd11, 5'd12, 5'd3};
  logic [31:0] reg_exp [10] = '{32'd5, 32'd5, 32'd10, 32'hFFFFFF65, 32'd1, 32'd0, 32'd10,
                                32'hA5, 32'd5, 32'd5};

  initial begin
    tick(2);
    rst = 1'b0;
    tick(10);
    check("reset_halted", {31'd0, halted}, 32'd1);
    check("reset_pc", pc, 32'd0);
    check("reset_instr", instr, 32'h200100A5);
    check("reset_retired", retired, 32'd0);
    check("cycle_10", dut.cycle_q, 32'd10);

    for (int i = 1; i <= 3; i++) do_step(1'b0, 32'(4 * i), 32'(i));
    check("halt_dataadr", dataadr, 32'h20);
    check("halt_writedata", writedata, 32'd5);
    check("halt_mw_gated", {31'd0, memwrite}, 32'd0);
    step_reset(1'b1);

    for (int i = 1; i <= 3; i++) do_step(1'b0, 32'(4 * i), 32'(i));

    bp_en = 1'b1;
    bp_addr = 32'h10;
    dbg_resume_req = 1'b1;
    tick(1);
    dbg_resume_req = 1'b0;
    wait_halt(20);
    check("bp_pc", pc, 32'h10);
    check("bp_retired", retired, 32'd4);

    dbg_resume_req = 1'b1;
    tick(1);
    dbg_resume_req = 1'b0;
    tick(19);
    check("no_retrig_halted", {31'd0, halted}, 32'd0);
    check("no_retrig_pc", pc, 32'h3C);
    check("no_retrig_retired", retired, 32'd23);
    bp_addr = 32'h3C;
    tick(1);
    check("bp2_halted", {31'd0, halted}, 32'd1);
    check("bp2_retired", retired, 32'd23);
    check("gpio_a5", {24'd0, gpio_out}, 32'hA5);
    for (int i = 0; i < 10; i++) begin
      ra_debug = reg_idx[i];
      #1;
      check($sformatf("reg%0d", reg_idx[i]), ra_debug_data, reg_exp[i]);
    end

    do_step(1'b1, 32'h3C, 32'd24);
    tick(3);
    check("step_prio_halted", {31'd0, halted}, 32'd1);
    check("step_prio_retired", retired, 32'd24);

    dbg_resume_req = 1'b1;
    tick(1);
    dbg_resume_req = 1'b0;
    wait_halt(10);
    check("resume_bp_retired", retired, 32'd25);

    bp_en = 1'b0;
    dbg_resume_req = 1'b1;
    tick(1);
    dbg_resume_req = 1'b0;
    tick(3);
    check("run_halted", {31'd0, halted}, 32'd0);
    check("run_retired", retired, 32'd28);
    dbg_halt_req = 1'b1;
    bp_en = 1'b1;
    tick(1);
    check("halt_bp_halted", {31'd0, halted}, 32'd1);
    check("halt_bp_retired", retired, 32'd28);
    dbg_halt_req = 1'b0;
    tick(2);
    check("halt_hold_retired", retired, 32'd28);

    step_reset(1'b0);
    tick(3);
    check("post_rst_retired", retired, 32'd0);
    check("post_rst_halted", {31'd0, halted}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
